player_missile_ctrl: RTL and testbench
======================================

Name: player_missile_ctrl

Overview:
Downstream consumer of the player-ship position from the ship-movement stage. It launches a single player missile from the ship's top-centre on a fire keypress, advances it upward once per frame, and retires it at the top boundary or on a hit. It also enforces a frame-based cooldown between shots. Its outputs feed the missile draw/bitmap object and the collision logic.

Parameters:
FIXED_POINT_MULTIPLIER, 64, sub-pixel scale (2^n); internal Y is pixel*64
MISSILE_SPEED, 512, upward step per frame in fixed point (8 px/frame)
SHIP_WIDTH, 64, ship sprite width in px
MISSILE_WIDTH, 4, missile sprite width in px
MISSILE_HEIGHT, 16, missile sprite height in px
TOP_BOUNDARY, 0, lowest legal missileTopLeftY in px
COOLDOWN_FRAMES, 8, frames after retirement before the next launch is accepted

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per frame
isGameMode  in  1  1 = gameplay active
fireKey  in  1  fire key level (held = 1)
shipTopLeftX  in  11 signed  ship top-left X, px
shipTopLeftY  in  11 signed  ship top-left Y, px
collision  in  1  missile hit alien/shield; level or pulse
missileTopLeftX  out  11 signed  missile top-left X, px
missileTopLeftY  out  11 signed  missile top-left Y, px
missileActive  out  1  missile in flight; draw enable
shotFired  out  1  one-cycle pulse on the launch cycle (sound/score)

Behaviour:
- Decided interface: one clock (clk); reset is synchronous and active-high (reset). All state updates occur on posedge clk only.
- Reset values: state=IDLE, missileTopLeftX=0, missileTopLeftY=0, missileActive=0, shotFired=0, cooldown counter=0, pending request=0, fireKey_d=0.
- Fire detect:
  - fireEdge = fireKey & ~fireKey_d, where fireKey_d is registered every cycle.
  - fireEdge sets the pending request. Holding the key never auto-repeats.
  - fireEff = pending | fireEdge, so an edge coincident with startOfFrame counts in that cycle.
  - In FLYING or COOLDOWN, fireEdge is discarded and pending is cleared. Requests are not queued across a shot.
- State IDLE:
  - On startOfFrame & isGameMode & fireEff, in the same clock: X <= shipTopLeftX + SHIP_WIDTH/2 - MISSILE_WIDTH/2; Yfp <= (shipTopLeftY - MISSILE_HEIGHT)*64; missileActive <= 1; shotFired <= 1 for one cycle; pending <= 0; go to FLYING.
  - Ship coordinates are sampled only on this cycle. X stays frozen for the whole flight.
- State FLYING:
  - collision=1 on any cycle: missileActive <= 0, load cooldown, go to COOLDOWN. Collision has priority over a coincident startOfFrame step.
  - Otherwise, on startOfFrame: nextY = Yfp - MISSILE_SPEED.
    - If (nextY >>> 6) < TOP_BOUNDARY: retire (missileActive <= 0, go to COOLDOWN; Y holds its last value).
    - Else Yfp <= nextY.
- State COOLDOWN:
  - Counter loads COOLDOWN_FRAMES on entry and decrements on each startOfFrame.
  - When the counter is 0 at a startOfFrame, go to IDLE. A launch is first possible at the following startOfFrame.
  - If COOLDOWN_FRAMES = 0, retirement goes directly to IDLE.
  - collision is ignored in COOLDOWN.
- Arithmetic:
  - Yfp is a 32-bit signed int.
  - Pixel output = arithmetic shift right by log2(FIXED_POINT_MULTIPLIER) (floor), truncated to 11 bits.
  - X is computed in 11-bit signed with no clamping. The ship stage guarantees 5..570, giving missile X 35..600.
- Outputs: missileTopLeftX and missileTopLeftY hold their last values when inactive. Consumers must gate on missileActive.
- isGameMode=0: state goes to IDLE, missileActive <= 0, pending <= 0, cooldown counter <= 0, on the next clock regardless of state. Coordinates hold.
- Reset asserted mid-flight: all state and outputs return to reset values on that clock edge.
- shotFired is never high for more than one cycle.

Test Plan:
- Launch: ship (280,438), gameMode=1; pulse fireKey, then startOfFrame -> same edge: shotFired=1 for 1 cycle, active=1, X=310, Y=422. Next 3 frames -> Y=414, 406, 398; X stays 310 even if the ship moves to 400.
- Top retire: continue flight -> Y steps by 8 down to 6 (52 frames after launch). Next frame (-2 < 0) -> active=0, Y holds 6. Fire edges in the next 8 frames -> ignored. Launch succeeds at the 10th frame after retirement.
- Collision priority: mid-flight at Y=350, assert collision on the same cycle as startOfFrame -> active=0, Y stays 350, enters COOLDOWN.
- No auto-repeat: hold fireKey high through launch, flight and cooldown -> exactly one shotFired. Release then press -> second launch at the next startOfFrame after IDLE.
- Mode / reset: drop isGameMode mid-flight -> active=0 next cycle, then immediate launch possible once the mode returns. Assert reset mid-flight -> all outputs 0 next edge.
- Edge+frame coincidence: fireKey rise on the same cycle as startOfFrame in IDLE -> launch in that cycle.

Source files
------------

// File: rtl/player_missile_ctrl_if.sv
// Signal bundle between the frame/ship/collision sources and the player missile controller.
// No valid/ready: startOfFrame is a one-cycle strobe, collision is a level or pulse; everything is sampled on posedge clk.
interface player_missile_ctrl_if;
   logic               startOfFrame;
   logic               isGameMode;
   logic               fireKey;
   logic signed [10:0] shipTopLeftX;
   logic signed [10:0] shipTopLeftY;
   logic               collision;
   logic signed [10:0] missileTopLeftX;
   logic signed [10:0] missileTopLeftY;
   logic               missileActive;
   logic               shotFired;

   modport master (
      output startOfFrame, isGameMode, fireKey, shipTopLeftX, shipTopLeftY, collision,
      input  missileTopLeftX, missileTopLeftY, missileActive, shotFired
   );

   modport slave (
      input  startOfFrame, isGameMode, fireKey, shipTopLeftX, shipTopLeftY, collision,
      output missileTopLeftX, missileTopLeftY, missileActive, shotFired
   );
endinterface

// File: rtl/player_missile_ctrl.sv
// Single player missile: launches from the ship's top-centre on a fire edge, climbs once per frame,
// retires at the top or on a hit, then waits a frame-counted cooldown before the next shot.
module player_missile_ctrl #(
   parameter int FIXED_POINT_MULTIPLIER = 64,
   parameter int MISSILE_SPEED          = 512,
   parameter int SHIP_WIDTH             = 64,
   parameter int MISSILE_WIDTH          = 4,
   parameter int MISSILE_HEIGHT         = 16,
   parameter int TOP_BOUNDARY           = 0,
   parameter int COOLDOWN_FRAMES        = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   player_missile_ctrl_if.slave bus,
   output logic [1:0]           o_dbg_state
);
   localparam int FP_SHIFT = $clog2(FIXED_POINT_MULTIPLIER);
   localparam int X_OFFSET = SHIP_WIDTH / 2 - MISSILE_WIDTH / 2;
   localparam int CNT_W    = $clog2(COOLDOWN_FRAMES + 2);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FLYING   = 2'd1,
      S_COOLDOWN = 2'd2
   } state_t;

   state_t             r_state, w_next_state;
   logic               r_fire_d, r_pending, r_shot;
   logic [CNT_W-1:0]   r_cd_cnt;
   logic signed [10:0] r_x;
   logic signed [31:0] r_yfp;

   logic               w_fire_edge, w_fire_eff, w_top_out;
   logic               w_launch, w_hit, w_step, w_retire;
   logic signed [31:0] w_ship_y_ext, w_launch_yfp, w_next_yfp, w_next_ypx;

   assign w_fire_edge  = bus.fireKey & ~r_fire_d;
   assign w_fire_eff   = r_pending | w_fire_edge;
   assign w_ship_y_ext = {{21{bus.shipTopLeftY[10]}}, bus.shipTopLeftY};
   assign w_launch_yfp = (w_ship_y_ext - MISSILE_HEIGHT) * FIXED_POINT_MULTIPLIER;
   assign w_next_yfp   = r_yfp - MISSILE_SPEED;
   assign w_next_ypx   = w_next_yfp >>> FP_SHIFT;
   assign w_top_out    = w_next_ypx < TOP_BOUNDARY;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (!bus.isGameMode) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:     if (w_launch) w_next_state = S_FLYING;
            S_FLYING:   if (w_hit | w_retire)
                           w_next_state = (COOLDOWN_FRAMES == 0) ? S_IDLE : S_COOLDOWN;
            S_COOLDOWN: if (bus.startOfFrame && r_cd_cnt == '0) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
         endcase
      end
   end

   // Collision outranks a coincident frame step, so a hit never advances Y.
   always_comb begin
      w_launch = 1'b0;
      w_hit    = 1'b0;
      w_step   = 1'b0;
      w_retire = 1'b0;
      if (bus.isGameMode) begin
         case (r_state)
            S_IDLE:   w_launch = bus.startOfFrame & w_fire_eff;
            S_FLYING: begin
               w_hit    = bus.collision;
               w_step   = ~bus.collision & bus.startOfFrame & ~w_top_out;
               w_retire = ~bus.collision & bus.startOfFrame & w_top_out;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fire_d  <= 1'b0;
         r_pending <= 1'b0;
         r_shot    <= 1'b0;
         r_cd_cnt  <= '0;
         r_x       <= '0;
         r_yfp     <= '0;
      end else begin
         r_fire_d <= bus.fireKey;
         r_shot   <= w_launch;
         // A request only survives while idle; it is never carried across a shot.
         if (!bus.isGameMode || r_state != S_IDLE || w_launch) r_pending <= 1'b0;
         else if (w_fire_edge)                                 r_pending <= 1'b1;
         if (w_launch) begin
            r_x   <= bus.shipTopLeftX + 11'(X_OFFSET);
            r_yfp <= w_launch_yfp;
         end else if (w_step) begin
            r_yfp <= w_next_yfp;
         end
         if (!bus.isGameMode)
            r_cd_cnt <= '0;
         else if (w_hit | w_retire)
            r_cd_cnt <= CNT_W'(COOLDOWN_FRAMES);
         else if (r_state == S_COOLDOWN && bus.startOfFrame && r_cd_cnt != '0)
            r_cd_cnt <= r_cd_cnt - CNT_W'(1);
      end
   end

   assign bus.missileTopLeftX = r_x;
   assign bus.missileTopLeftY = r_yfp[FP_SHIFT +: 11];
   assign bus.missileActive   = (r_state == S_FLYING);
   assign bus.shotFired       = r_shot;
   assign o_dbg_state         = r_state;
endmodule

// File: tb/tb_player_missile_ctrl.sv
// Directed scenarios plus a randomized run, all checked against a pixel-level model of the missile rules.
module tb_player_missile_ctrl;
   localparam int LAUNCH_DX   = 30;
   localparam int LAUNCH_DY   = 16;
   localparam int STEP_PX     = 8;
   localparam int COOL_FRAMES = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] dbg_state;
   int         n_checks = 0;
   int         n_fail = 0;

   player_missile_ctrl_if bus ();
   player_missile_ctrl dut (.clk(clk), .reset(reset), .bus(bus), .o_dbg_state(dbg_state));

   always #5 clk = ~clk;

   // Reference model: whole-pixel Y, a "frames left before ready" wait, and an armed flag.
   bit m_active, m_shot, m_armed, m_key_d;
   int m_x, m_y, m_wait;
   logic [21:0] exp_q[$];

   task automatic model_step();
      bit edge_w;
      if (reset) begin
         m_active = 0; m_shot = 0; m_armed = 0; m_key_d = 0;
         m_x = 0; m_y = 0; m_wait = 0;
         return;
      end
      edge_w  = bus.fireKey && !m_key_d;
      m_key_d = bus.fireKey;
      m_shot  = 0;
      if (!bus.isGameMode) begin
         m_active = 0; m_wait = 0; m_armed = 0;
      end else if (m_active) begin
         m_armed = 0;
         if (bus.collision) begin
            m_active = 0; m_wait = COOL_FRAMES + 1;
         end else if (bus.startOfFrame) begin
            if (m_y - STEP_PX < 0) begin
               m_active = 0; m_wait = COOL_FRAMES + 1;
            end else begin
               m_y = m_y - STEP_PX;
            end
         end
      end else if (m_wait > 0) begin
         m_armed = 0;
         if (bus.startOfFrame) m_wait = m_wait - 1;
      end else if (bus.startOfFrame && (m_armed || edge_w)) begin
         m_active = 1; m_shot = 1; m_armed = 0;
         m_x = int'($signed(bus.shipTopLeftX)) + LAUNCH_DX;
         m_y = int'($signed(bus.shipTopLeftY)) - LAUNCH_DY;
         exp_q.push_back({11'(m_x), 11'(m_y)});
      end else if (edge_w) begin
         m_armed = 1;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      bus.startOfFrame = 1'b1; cycle();
      bus.startOfFrame = 1'b0; cycle(); cycle();
   endtask

   task automatic set_ship(input int x, input int y);
      bus.shipTopLeftX = 11'(x);
      bus.shipTopLeftY = 11'(y);
   endtask

   task automatic test_reset();
      reset = 1'b1; cycle(); cycle();
      n_checks++;
      if (bus.missileTopLeftX !== 11'd0 || bus.missileTopLeftY !== 11'd0 ||
          bus.missileActive !== 1'b0 || bus.shotFired !== 1'b0 || dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got x=%0d y=%0d act=%0b shot=%0b st=%0d expected all 0",
                  bus.missileTopLeftX, bus.missileTopLeftY, bus.missileActive, bus.shotFired, dbg_state);
      end
      reset = 1'b0; cycle();
   endtask

   task automatic test_launch();
      bus.fireKey = 1'b1; cycle();
      bus.fireKey = 1'b0; cycle();
      bus.startOfFrame = 1'b1; cycle();
      n_checks++;
      if (bus.shotFired !== 1'b1 || bus.missileActive !== 1'b1 ||
          $signed(bus.missileTopLeftX) !== 11'sd310 || $signed(bus.missileTopLeftY) !== 11'sd422) begin
         n_fail++;
         $display("FAIL launch: got shot=%0b act=%0b x=%0d y=%0d expected 1 1 310 422",
                  bus.shotFired, bus.missileActive, $signed(bus.missileTopLeftX), $signed(bus.missileTopLeftY));
      end
      bus.startOfFrame = 1'b0; cycle();
      n_checks++;
      if (bus.shotFired !== 1'b0) begin
         n_fail++; $display("FAIL shot_one_cycle: got %0b expected 0", bus.shotFired);
      end
      cycle();
      set_ship(400, 300);
      for (int k = 1; k <= 3; k++) begin
         frame();
         n_checks++;
         if ($signed(bus.missileTopLeftY) !== 11'(422 - 8 * k) || $signed(bus.missileTopLeftX) !== 11'sd310) begin
            n_fail++;
            $display("FAIL flight_step%0d: got x=%0d y=%0d expected x=310 y=%0d", k,
                     $signed(bus.missileTopLeftX), $signed(bus.missileTopLeftY), 422 - 8 * k);
         end
      end
   endtask

   task automatic test_top_retire();
      for (int k = 4; k <= 52; k++) frame();
      n_checks++;
      if ($signed(bus.missileTopLeftY) !== 11'sd6 || bus.missileActive !== 1'b1) begin
         n_fail++;
         $display("FAIL top_last_step: got y=%0d act=%0b expected y=6 act=1",
                  $signed(bus.missileTopLeftY), bus.missileActive);
      end
      frame();
      n_checks++;
      if ($signed(bus.missileTopLeftY) !== 11'sd6 || bus.missileActive !== 1'b0 || dbg_state !== 2'd2) begin
         n_fail++;
         $display("FAIL top_retire: got y=%0d act=%0b st=%0d expected y=6 act=0 st=2",
                  $signed(bus.missileTopLeftY), bus.missileActive, dbg_state);
      end
      for (int i = 1; i <= COOL_FRAMES; i++) begin
         bus.fireKey = 1'b1; bus.startOfFrame = 1'b1; cycle();
         n_checks++;
         if (bus.shotFired !== 1'b0 || bus.missileActive !== 1'b0) begin
            n_fail++;
            $display("FAIL cooldown_ignore%0d: got shot=%0b act=%0b expected 0 0", i, bus.shotFired, bus.missileActive);
         end
         bus.fireKey = 1'b0; bus.startOfFrame = 1'b0; cycle(); cycle();
      end
      frame();
      set_ship(280, 374);
      bus.fireKey = 1'b1; bus.startOfFrame = 1'b1; cycle();
      n_checks++;
      if (bus.shotFired !== 1'b1 || $signed(bus.missileTopLeftX) !== 11'sd310 ||
          $signed(bus.missileTopLeftY) !== 11'sd358) begin
         n_fail++;
         $display("FAIL relaunch_frame10: got shot=%0b x=%0d y=%0d expected 1 310 358",
                  bus.shotFired, $signed(bus.missileTopLeftX), $signed(bus.missileTopLeftY));
      end
      bus.fireKey = 1'b0; bus.startOfFrame = 1'b0; cycle(); cycle();
   endtask

   task automatic test_collision_priority();
      frame();
      n_checks++;
      if ($signed(bus.missileTopLeftY) !== 11'sd350) begin
         n_fail++; $display("FAIL pre_collision_y: got %0d expected 350", $signed(bus.missileTopLeftY));
      end
      bus.collision = 1'b1; bus.startOfFrame = 1'b1; cycle();
      n_checks++;
      if (bus.missileActive !== 1'b0 || $signed(bus.missileTopLeftY) !== 11'sd350 || dbg_state !== 2'd2) begin
         n_fail++;
         $display("FAIL collision_priority: got act=%0b y=%0d st=%0d expected 0 350 2",
                  bus.missileActive, $signed(bus.missileTopLeftY), dbg_state);
      end
      bus.startOfFrame = 1'b0; cycle();
      bus.collision = 1'b0;
      n_checks++;
      if (dbg_state !== 2'd2) begin
         n_fail++; $display("FAIL collision_in_cooldown: got st=%0d expected 2", dbg_state);
      end
      for (int i = 0; i < COOL_FRAMES; i++) frame();
      n_checks++;
      if (dbg_state !== 2'd2) begin
         n_fail++; $display("FAIL cooldown_frame8: got st=%0d expected 2", dbg_state);
      end
      frame();
      n_checks++;
      if (dbg_state !== 2'd0) begin
         n_fail++; $display("FAIL cooldown_exit: got st=%0d expected 0", dbg_state);
      end
   endtask

   task automatic test_no_auto_repeat();
      int shots = 0;
      set_ship(280, 438);
      bus.fireKey = 1'b1; cycle();
      for (int i = 0; i < 67 * 3; i++) begin
         bus.startOfFrame = (i % 3 == 0);
         cycle();
         if (bus.shotFired === 1'b1) shots++;
      end
      bus.startOfFrame = 1'b0;
      n_checks++;
      if (shots != 1 || dbg_state !== 2'd0) begin
         n_fail++; $display("FAIL held_key_shots: got %0d shots st=%0d expected 1 shot st=0", shots, dbg_state);
      end
      bus.fireKey = 1'b0; cycle();
      bus.fireKey = 1'b1; cycle();
      bus.fireKey = 1'b0; cycle();
      bus.startOfFrame = 1'b1; cycle();
      bus.startOfFrame = 1'b0;
      n_checks++;
      if (bus.shotFired !== 1'b1 || bus.missileActive !== 1'b1) begin
         n_fail++; $display("FAIL repress_launch: got shot=%0b act=%0b expected 1 1", bus.shotFired, bus.missileActive);
      end
      cycle();
   endtask

   task automatic test_mode_drop();
      bus.isGameMode = 1'b0; cycle();
      n_checks++;
      if (bus.missileActive !== 1'b0 || dbg_state !== 2'd0 || $signed(bus.missileTopLeftY) !== 11'sd422 ||
          $signed(bus.missileTopLeftX) !== 11'sd310) begin
         n_fail++;
         $display("FAIL mode_drop: got act=%0b st=%0d x=%0d y=%0d expected 0 0 310 422", bus.missileActive,
                  dbg_state, $signed(bus.missileTopLeftX), $signed(bus.missileTopLeftY));
      end
      bus.isGameMode = 1'b1; bus.fireKey = 1'b1; bus.startOfFrame = 1'b1; cycle();
      n_checks++;
      if (bus.shotFired !== 1'b1 || bus.missileActive !== 1'b1) begin
         n_fail++; $display("FAIL mode_return_launch: got shot=%0b act=%0b expected 1 1", bus.shotFired, bus.missileActive);
      end
      bus.fireKey = 1'b0; bus.startOfFrame = 1'b0; cycle();
   endtask

   task automatic test_reset_mid_flight();
      frame();
      reset = 1'b1; cycle();
      n_checks++;
      if (bus.missileTopLeftX !== 11'd0 || bus.missileTopLeftY !== 11'd0 || bus.missileActive !== 1'b0 ||
          bus.shotFired !== 1'b0 || dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid_flight: got x=%0d y=%0d act=%0b shot=%0b st=%0d expected all 0",
                  bus.missileTopLeftX, bus.missileTopLeftY, bus.missileActive, bus.shotFired, dbg_state);
      end
      reset = 1'b0; cycle();
   endtask

   task automatic test_edge_frame_coincidence();
      bus.fireKey = 1'b1; bus.startOfFrame = 1'b1; cycle();
      n_checks++;
      if (bus.shotFired !== 1'b1 || $signed(bus.missileTopLeftX) !== 11'sd310 ||
          $signed(bus.missileTopLeftY) !== 11'sd422) begin
         n_fail++;
         $display("FAIL edge_frame_coincide: got shot=%0b x=%0d y=%0d expected 1 310 422",
                  bus.shotFired, $signed(bus.missileTopLeftX), $signed(bus.missileTopLeftY));
      end
      bus.fireKey = 1'b0; bus.startOfFrame = 1'b0; cycle();
   endtask

   task automatic test_random();
      logic [10:0] ex, ey;
      logic [21:0] exp_xy;
      int          mode_off = 0;
      exp_q.delete();
      for (int i = 0; i < 3000; i++) begin
         bus.startOfFrame = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0) bus.fireKey = ~bus.fireKey;
         bus.collision = ($urandom_range(0, 39) == 0);
         if (mode_off > 0) mode_off--;
         else if ($urandom_range(0, 299) == 0) mode_off = $urandom_range(1, 4);
         bus.isGameMode = (mode_off == 0);
         if ($urandom_range(0, 7) == 0) set_ship($urandom_range(5, 570), $urandom_range(20, 470));
         cycle();
         ex = 11'(m_x);
         ey = 11'(m_y);
         n_checks++;
         if (bus.missileActive !== m_active || bus.shotFired !== m_shot ||
             bus.missileTopLeftX !== ex || bus.missileTopLeftY !== ey) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got act=%0b shot=%0b x=%0d y=%0d expected %0b %0b %0d %0d", i,
                     bus.missileActive, bus.shotFired, $signed(bus.missileTopLeftX), $signed(bus.missileTopLeftY),
                     m_active, m_shot, $signed(ex), $signed(ey));
         end
         if (bus.shotFired === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL random_unexpected_shot: got shot at cycle %0d expected none", i);
            end else begin
               exp_xy = exp_q.pop_front();
               if ({bus.missileTopLeftX, bus.missileTopLeftY} !== exp_xy) begin
                  n_fail++;
                  $display("FAIL random_launch_xy: got %0d,%0d expected %0d,%0d", $signed(bus.missileTopLeftX),
                           $signed(bus.missileTopLeftY), $signed(exp_xy[21:11]), $signed(exp_xy[10:0]));
               end
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL random_missing_shots: got %0d unmatched launches expected 0", exp_q.size());
      end
   endtask

   initial begin
      bus.startOfFrame = 1'b0;
      bus.isGameMode   = 1'b1;
      bus.fireKey      = 1'b0;
      bus.collision    = 1'b0;
      set_ship(280, 438);
      test_reset();
      test_launch();
      test_top_retire();
      test_collision_priority();
      test_no_auto_repeat();
      test_mode_drop();
      test_reset_mid_flight();
      test_edge_frame_coincidence();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog expired");
   end
endmodule
